// File: rtl/dec_pkg.sv
// dec_pkg: RV32I opcodes, immediate kinds and the decoded-instruction record
package dec_pkg;
  localparam int DEC_XLEN = 32;
  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_JALR   = 7'h67;
  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;
  typedef struct packed {
    logic [DEC_XLEN-1:0] pc;
    logic [6:0]          opcode;
    logic [2:0]          func3;
    logic [6:0]          func7;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [DEC_XLEN-1:0] imm;
    logic                rs1_used;
    logic                rs2_used;
    logic                rd_we;
    logic                illegal;
  } dec_t;
endpackage

// File: rtl/inst_dec_core.sv
// inst_dec_core: combinational RV32I(+M) decode of one instruction into dec_t
module inst_dec_core
  import dec_pkg::*;
#(
  parameter int XLEN      = DEC_XLEN,
  parameter bit SUPPORT_M = 1'b0
) (
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  output dec_t            dec
);
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic r, i, l, s, b, lui, auipc, jal, jalr;
  logic bad_r, bad_i, bad, u1, u2, ud;
  logic [31:0] i32;
  imm_type_e it;
  assign op    = inst[6:0];
  assign f3    = inst[14:12];
  assign f7    = inst[31:25];
  assign r     = op == OP_R;
  assign i     = op == OP_IMM;
  assign l     = op == OP_LOAD;
  assign s     = op == OP_STORE;
  assign b     = op == OP_BRANCH;
  assign lui   = op == OP_LUI;
  assign auipc = op == OP_AUIPC;
  assign jal   = op == OP_JAL;
  assign jalr  = op == OP_JALR;
  assign bad_r = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) || (SUPPORT_M && f7 == 7'h01));
  assign bad_i = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
  assign bad   = inst[1:0] != 2'b11 || !(r | i | l | s | b | lui | auipc | jal | jalr)
              || (r && bad_r) || (i && bad_i)
              || (l && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7))
              || (s && f3 >= 3'd3) || (b && (f3 == 3'd2 || f3 == 3'd3))
              || (jalr && f3 != 3'd0);
  // illegal instructions keep only pc/opcode, so every use flag is gated by legality
  assign u1 = (r | i | l | s | b | jalr) & !bad;
  assign u2 = (r | s | b) & !bad;
  assign ud = (r | i | l | lui | auipc | jal | jalr) & !bad;
  assign it = (i | l | jalr) ? IMM_I : s ? IMM_S : b ? IMM_B : (lui | auipc) ? IMM_U : jal ? IMM_J : IMM_NONE;
  assign i32 = it == IMM_I ? {{20{inst[31]}}, inst[31:20]} :
               it == IMM_S ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
               it == IMM_B ? {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
               it == IMM_U ? {inst[31:12], 12'h000} :
               it == IMM_J ? {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} : 32'h0;
  always_comb begin
    dec.pc       = DEC_XLEN'(pc);
    dec.opcode   = op;
    dec.func3    = u1 ? f3 : 3'h0;
    dec.func7    = (r && !bad) ? f7 : 7'h00;
    dec.rs1      = u1 ? inst[19:15] : 5'h0;
    dec.rs2      = u2 ? inst[24:20] : 5'h0;
    dec.rd       = ud ? inst[11:7] : 5'h0;
    dec.imm      = bad ? '0 : DEC_XLEN'($signed(i32));
    dec.rs1_used = u1;
    dec.rs2_used = u2;
    dec.rd_we    = ud && inst[11:7] != 5'h0;
    dec.illegal  = bad;
  end
endmodule

// File: rtl/inst_dec_q.sv
// inst_dec_q: RV32I decode stage feeding a DEPTH-entry FIFO of decoded instructions
module inst_dec_q
  import dec_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 2,
  parameter bit SUPPORT_M = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [6:0]               opcode,
  output logic [2:0]               func3,
  output logic [6:0]               func7,
  output logic [4:0]               rs1,
  output logic [4:0]               rs2,
  output logic [4:0]               rd,
  output logic [XLEN-1:0]          imm,
  output logic                     rs1_used,
  output logic                     rs2_used,
  output logic                     rd_we,
  output logic                     illegal,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  dec_t d, h;
  dec_t q [DEPTH];
  logic [AW-1:0] wp, rp;
  logic push, pop;
  inst_dec_core #(.XLEN(XLEN), .SUPPORT_M(SUPPORT_M)) u_core (.inst(in_inst), .pc(in_pc), .dec(d));
  assign in_ready  = count < CW'(DEPTH);
  assign out_valid = count != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
    end
  always_ff @(posedge clk)
    if (push && !flush) q[wp] <= d;
  // an empty queue presents all-zero data regardless of stale storage
  assign h        = out_valid ? q[rp] : '0;
  assign out_pc   = XLEN'(h.pc);
  assign opcode   = h.opcode;
  assign func3    = h.func3;
  assign func7    = h.func7;
  assign rs1      = h.rs1;
  assign rs2      = h.rs2;
  assign rd       = h.rd;
  assign imm      = XLEN'(h.imm);
  assign rs1_used = h.rs1_used;
  assign rs2_used = h.rs2_used;
  assign rd_we    = h.rd_we;
  assign illegal  = h.illegal;
endmodule

// File: tb/tb_inst_dec_q.sv
// tb_inst_dec_q: directed vectors for the decode queue, with and without RV32M
module tb_inst_dec_q;
  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        rs1_used;
    logic        rs2_used;
    logic        rd_we;
    logic        illegal;
  } out_t;
  typedef struct {
    logic [31:0] inst;
    out_t        e0;
    out_t        e1;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_inst = '0, in_pc = '0;
  logic        ir [2], ov [2], u1_w [2], u2_w [2], we_w [2], il_w [2];
  logic [31:0] pc_w [2], imm_w [2];
  logic [6:0]  op_w [2], f7_w [2];
  logic [2:0]  f3_w [2];
  logic [4:0]  rs1_w [2], rs2_w [2], rd_w [2];
  logic [1:0]  cnt [2];
  out_t        got [2];
  int n_cmp = 0, n_bad = 0;
  vec_t v [14];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    inst_dec_q #(.XLEN(32), .DEPTH(2), .SUPPORT_M(g)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[g]),
      .in_inst(in_inst), .in_pc(in_pc), .out_valid(ov[g]), .out_ready(out_ready),
      .out_pc(pc_w[g]), .opcode(op_w[g]), .func3(f3_w[g]), .func7(f7_w[g]),
      .rs1(rs1_w[g]), .rs2(rs2_w[g]), .rd(rd_w[g]), .imm(imm_w[g]),
      .rs1_used(u1_w[g]), .rs2_used(u2_w[g]), .rd_we(we_w[g]), .illegal(il_w[g]), .count(cnt[g]));
    assign got[g] = {pc_w[g], op_w[g], f3_w[g], f7_w[g], rs1_w[g], rs2_w[g], rd_w[g], imm_w[g],
                     u1_w[g], u2_w[g], we_w[g], il_w[g]};
  end
  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask
  function automatic out_t mk(input logic [31:0] pc, input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [4:0] s1, input logic [4:0] s2,
                              input logic [4:0] d, input logic [31:0] im, input logic a1,
                              input logic a2, input logic we, input logic il);
    return '{pc, op, f3, f7, s1, s2, d, im, a1, a2, we, il};
  endfunction
  function automatic out_t bad(input logic [31:0] pc, input logic [6:0] op);
    return mk(pc, op, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction
  function automatic logic [31:0] pa(input int i);
    return 32'h100 + 32'(i) * 4;
  endfunction
  task automatic push_hold(input logic [31:0] pc);
    @(negedge clk);
    in_valid = 1'b1;
    in_inst  = 32'h00500093;
    in_pc    = pc;
  endtask
  initial begin
    v[0]  = '{32'h00500093, mk(pa(0), 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd5, 1'b1, 1'b0, 1'b1, 1'b0), '0};
    v[1]  = '{32'hFE000EE3, mk(pa(1), 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b1, 1'b1, 1'b0, 1'b0), '0};
    v[2]  = '{32'h02208133, bad(pa(2), 7'h33),
              mk(pa(2), 7'h33, 3'd0, 7'h01, 5'd1, 5'd2, 5'd2, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0)};
    v[3]  = '{32'hFF812283, mk(pa(3), 7'h03, 3'd2, 7'h00, 5'd2, 5'd0, 5'd5, 32'hFFFFFFF8, 1'b1, 1'b0, 1'b1, 1'b0), '0};
    v[4]  = '{32'h00322623, mk(pa(4), 7'h23, 3'd2, 7'h00, 5'd4, 5'd3, 5'd0, 32'd12, 1'b1, 1'b1, 1'b0, 1'b0), '0};
    v[5]  = '{32'h12345537, mk(pa(5), 7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd10, 32'h12345000, 1'b0, 1'b0, 1'b1, 1'b0), '0};
    v[6]  = '{32'h008000EF, mk(pa(6), 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd8, 1'b0, 1'b0, 1'b1, 1'b0), '0};
    v[7]  = '{32'h40315093, mk(pa(7), 7'h13, 3'd5, 7'h00, 5'd2, 5'd0, 5'd1, 32'h403, 1'b1, 1'b0, 1'b1, 1'b0), '0};
    v[8]  = '{32'h40311093, bad(pa(8), 7'h13), '0};
    v[9]  = '{32'h00109067, bad(pa(9), 7'h67), '0};
    v[10] = '{32'h00500090, bad(pa(10), 7'h10), '0};
    v[11] = '{32'h402081B3, mk(pa(11), 7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0), '0};
    v[12] = '{32'h00001017, mk(pa(12), 7'h17, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h1000, 1'b0, 1'b0, 1'b0, 1'b0), '0};
    v[13] = '{32'h00002063, bad(pa(13), 7'h63), '0};
    for (int i = 0; i < 14; i++) if (v[i].e1 == '0) v[i].e1 = v[i].e0;
    #3;
    chk("reset_valid", ov[0], 1'b0);
    chk("reset_count", cnt[0], 2'd0);
    chk("reset_ready", ir[0], 1'b1);
    chk("reset_data", got[0], '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_inst  = v[i].inst;
      in_pc    = pa(i);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), ov[0], 1'b1);
      chk($sformatf("vec%0d_m0", i), got[0], v[i].e0);
      chk($sformatf("vec%0d_m1", i), got[1], v[i].e1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk($sformatf("vec%0d_drained", i), cnt[0], 2'd0);
    end
    push_hold(32'h200);
    @(negedge clk);
    chk("full_cnt1", cnt[0], 2'd1);
    in_pc = 32'h204;
    @(negedge clk);
    chk("full_cnt2", cnt[0], 2'd2);
    chk("full_ready", ir[0], 1'b0);
    in_pc = 32'h208;
    @(negedge clk);
    chk("full_held_cnt", cnt[0], 2'd2);
    chk("full_head0", pc_w[0], 32'h200);
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_head1", pc_w[0], 32'h204);
    chk("full_cnt_pop", cnt[0], 2'd1);
    @(negedge clk);
    chk("full_head2", pc_w[0], 32'h208);
    chk("full_cnt_swap", cnt[0], 2'd1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_empty", ov[0], 1'b0);
    out_ready = 1'b0;
    push_hold(32'h300);
    @(negedge clk);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_pc = 32'h300 + 32'(k) * 4;
      @(negedge clk);
      chk($sformatf("pp%0d_cnt", k), cnt[0], 2'd1);
      chk($sformatf("pp%0d_head", k), pc_w[0], 32'h300 + 32'(k) * 4);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("pp_drained", cnt[0], 2'd0);
    out_ready = 1'b0;
    push_hold(32'h400);
    @(negedge clk);
    in_pc = 32'h404;
    @(negedge clk);
    chk("fl_full", cnt[0], 2'd2);
    flush = 1'b1;
    out_ready = 1'b1;
    in_pc = 32'h408;
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("fl_cnt", cnt[0], 2'd0);
    chk("fl_valid", ov[0], 1'b0);
    chk("fl_data", got[0], '0);
    push_hold(32'h500);
    @(negedge clk);
    flush = 1'b1;
    in_pc = 32'h504;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_push_drop", cnt[0], 2'd0);
    push_hold(32'h600);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_pre_valid", ov[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", ov[0], 1'b0);
    chk("rst_async_cnt", cnt[0], 2'd0);
    chk("rst_async_data0", got[0], '0);
    chk("rst_async_data1", got[1], '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_after_cnt", cnt[0], 2'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
